// File: rtl/instr_register_pkg.sv
// Shared types and default sizes for the pipelined instruction register.
package instr_register_pkg;

    localparam int unsigned IR_OP_W        = 16;
    localparam int unsigned IR_NUM_ENTRIES = 32;
    localparam int unsigned IR_RES_W       = 2 * IR_OP_W;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef struct packed {
        opcode_t                    opc;
        logic signed [IR_OP_W-1:0]  op_a;
        logic signed [IR_OP_W-1:0]  op_b;
        logic signed [IR_RES_W-1:0] rezultat;
        logic                       dbz;
    } instruction_t;

endpackage

// File: rtl/ir_alu.sv
// Combinational signed ALU used in the write-retire stage; operands are
// sign-extended to the full result width before the operation.
module ir_alu
    import instr_register_pkg::*;
#(
    parameter  int unsigned OP_W  = IR_OP_W,
    localparam int unsigned RES_W = 2 * OP_W
) (
    input  opcode_t                  opcode,
    input  logic signed [OP_W-1:0]   a,
    input  logic signed [OP_W-1:0]   b,
    output logic signed [RES_W-1:0]  result,
    output logic                     dbz
);

    logic signed [RES_W-1:0] a_x;
    logic signed [RES_W-1:0] b_x;

    always_comb begin
        a_x    = {{OP_W{a[OP_W-1]}}, a};
        b_x    = {{OP_W{b[OP_W-1]}}, b};
        result = '0;
        dbz    = 1'b0;
        case (opcode)
            ZERO:  result = '0;
            PASSA: result = a_x;
            PASSB: result = b_x;
            ADD:   result = a_x + b_x;
            SUB:   result = a_x - b_x;
            MULT:  result = a_x * b_x;
            // Division by zero is trapped before the divider is evaluated.
            DIV: begin
                if (b_x == '0) dbz = 1'b1;
                else           result = a_x / b_x;
            end
            MOD: begin
                if (b_x == '0) dbz = 1'b1;
                else           result = a_x % b_x;
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_register_pipe.sv
// Two-stage instruction register: capture (S1), ALU + retire (S2), registered read.
// Optional macro IR_FWD_EN forwards a retiring entry to a same-address read.
module instr_register_pipe
    import instr_register_pkg::*;
#(
    parameter  int unsigned OP_W        = IR_OP_W,
    parameter  int unsigned NUM_ENTRIES = IR_NUM_ENTRIES,
    localparam int unsigned ADDR_W      = $clog2(NUM_ENTRIES),
    localparam int unsigned RES_W       = 2 * OP_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load_en,
    input  logic [ADDR_W-1:0]       write_pointer,
    input  opcode_t                 opcode,
    input  logic signed [OP_W-1:0]  operand_a,
    input  logic signed [OP_W-1:0]  operand_b,
    input  logic [ADDR_W-1:0]       read_pointer,
    output instruction_t            instruction_word,
    output logic                    rd_valid,
    output logic                    wr_inflight,
    output logic [ADDR_W:0]         valid_count
);

    logic                    s1_vld_q;
    opcode_t                 s1_opc_q;
    logic signed [OP_W-1:0]  s1_a_q;
    logic signed [OP_W-1:0]  s1_b_q;
    logic [ADDR_W-1:0]       s1_ptr_q;

    instruction_t            mem_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]  valid_q;
    logic [ADDR_W:0]         valid_count_q, valid_count_d;

    instruction_t            rd_word_q, rd_word_d;
    logic                    rd_valid_q, rd_valid_d;

    logic signed [RES_W-1:0] alu_res;
    logic                    alu_dbz;
    instruction_t            wr_entry;

    ir_alu #(.OP_W(OP_W)) u_alu (
        .opcode (s1_opc_q),
        .a      (s1_a_q),
        .b      (s1_b_q),
        .result (alu_res),
        .dbz    (alu_dbz)
    );

    always_comb begin
        wr_entry          = '0;
        wr_entry.opc      = s1_opc_q;
        wr_entry.op_a     = s1_a_q;
        wr_entry.op_b     = s1_b_q;
        wr_entry.rezultat = alu_res;
        wr_entry.dbz      = alu_dbz;
    end

    // Only a transition from invalid to valid changes the population count.
    always_comb begin
        valid_count_d = valid_count_q;
        if (s1_vld_q && !valid_q[s1_ptr_q])
            valid_count_d = valid_count_q + (ADDR_W + 1)'(1);
    end

    always_comb begin
        rd_valid_d = valid_q[read_pointer];
        rd_word_d  = rd_valid_d ? mem_q[read_pointer] : '0;
`ifdef IR_FWD_EN
        if (s1_vld_q && (s1_ptr_q == read_pointer)) begin
            rd_word_d  = wr_entry;
            rd_valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_q      <= 1'b0;
            s1_opc_q      <= ZERO;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_ptr_q      <= '0;
            valid_q       <= '0;
            valid_count_q <= '0;
            rd_word_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            s1_vld_q <= load_en;
            if (load_en) begin
                s1_opc_q <= opcode;
                s1_a_q   <= operand_a;
                s1_b_q   <= operand_b;
                s1_ptr_q <= write_pointer;
            end
            if (s1_vld_q)
                valid_q[s1_ptr_q] <= 1'b1;
            valid_count_q <= valid_count_d;
            rd_word_q     <= rd_word_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    // Storage needs no reset: invalid entries are masked to zero on read.
    always_ff @(posedge clk) begin
        if (s1_vld_q)
            mem_q[s1_ptr_q] <= wr_entry;
    end

    assign instruction_word = rd_word_q;
    assign rd_valid         = rd_valid_q;
    assign wr_inflight      = s1_vld_q;
    assign valid_count      = valid_count_q;

endmodule

// File: tb/tb_instr_register_pipe.sv
// Directed self-checking bench for instr_register_pipe.
module tb_instr_register_pipe;
    import instr_register_pkg::*;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                load_en;
    logic [4:0]          write_pointer;
    opcode_t             opcode;
    logic signed [15:0]  operand_a;
    logic signed [15:0]  operand_b;
    logic [4:0]          read_pointer;
    instruction_t        instruction_word;
    logic                rd_valid;
    logic                wr_inflight;
    logic [5:0]          valid_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    instr_register_pipe #(.OP_W(16), .NUM_ENTRIES(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .load_en          (load_en),
        .write_pointer    (write_pointer),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .rd_valid         (rd_valid),
        .wr_inflight      (wr_inflight),
        .valid_count      (valid_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic instruction_t mk(input opcode_t o, input logic signed [15:0] a,
                                        input logic signed [15:0] b,
                                        input logic signed [31:0] r, input logic d);
        instruction_t w;
        w.opc = o; w.op_a = a; w.op_b = b; w.rezultat = r; w.dbz = d;
        return w;
    endfunction

    // Drives one write for one cycle starting at a negedge; returns at the next negedge.
    task automatic wr(input logic [4:0] p, input opcode_t o,
                      input logic signed [15:0] a, input logic signed [15:0] b);
        load_en = 1'b1; write_pointer = p; opcode = o; operand_a = a; operand_b = b;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Read issued at a negedge, result sampled one cycle later.
    task automatic rd_check(input string tag, input logic [4:0] p,
                            input instruction_t exp_w, input logic exp_v);
        read_pointer = p;
        @(negedge clk);
        check({tag, ".word"}, 128'(instruction_word), 128'(exp_w));
        check({tag, ".valid"}, 128'(rd_valid), 128'(exp_v));
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; load_en = 1'b0; write_pointer = '0; opcode = ZERO;
        operand_a = '0; operand_b = '0; read_pointer = '0;

        // 1. Reset
        idle(2);
        check("rst.word", 128'(instruction_word), 128'(0));
        check("rst.valid", 128'(rd_valid), 128'(0));
        check("rst.inflight", 128'(wr_inflight), 128'(0));
        check("rst.count", 128'(valid_count), 128'(0));
        reset_n = 1'b1;
        for (int unsigned i = 0; i < 32; i++)
            rd_check($sformatf("rst.rd%0d", i), 5'(i), '0, 1'b0);

        // 2. Arithmetic: 7 + -3 = 4
        load_en = 1'b1; write_pointer = 5'd3; opcode = ADD;
        operand_a = 16'sd7; operand_b = -16'sd3;
        @(negedge clk);
        load_en = 1'b0;
        check("add.inflight", 128'(wr_inflight), 128'(1));
        idle(1);
        check("add.inflight_clr", 128'(wr_inflight), 128'(0));
        rd_check("add", 5'd3, mk(ADD, 16'sd7, -16'sd3, 32'sd4, 1'b0), 1'b1);
        check("add.count", 128'(valid_count), 128'(1));

        // 3. Multiply: full 32-bit product
        wr(5'd4, MULT, -16'sd32768, -16'sd32768);
        idle(1);
        rd_check("mult", 5'd4, mk(MULT, -16'sd32768, -16'sd32768, 32'h4000_0000, 1'b0), 1'b1);

        // 4. Division cases
        wr(5'd6, DIV, 16'sd9, 16'sd0);
        wr(5'd7, MOD, -16'sd7, 16'sd2);
        wr(5'd8, DIV, -16'sd7, 16'sd2);
        wr(5'd10, MOD, 16'sd5, 16'sd0);
        idle(1);
        rd_check("div0", 5'd6, mk(DIV, 16'sd9, 16'sd0, 32'sd0, 1'b1), 1'b1);
        rd_check("mod", 5'd7, mk(MOD, -16'sd7, 16'sd2, -32'sd1, 1'b0), 1'b1);
        rd_check("div", 5'd8, mk(DIV, -16'sd7, 16'sd2, -32'sd3, 1'b0), 1'b1);
        rd_check("mod0", 5'd10, mk(MOD, 16'sd5, 16'sd0, 32'sd0, 1'b1), 1'b1);
        check("div.count", 128'(valid_count), 128'(6));

        // 5. Streaming SUB a=5i b=7 to every entry, then overwrite @5 back-to-back
        for (int unsigned i = 0; i < 32; i++) begin
            load_en = 1'b1; write_pointer = 5'(i); opcode = SUB;
            operand_a = 16'(5 * i); operand_b = 16'sd7;
            @(negedge clk);
        end
        write_pointer = 5'd5; opcode = MULT; operand_a = -16'sd3; operand_b = 16'sd11;
        @(negedge clk);
        load_en = 1'b0;
        idle(1);
        check("stream.count", 128'(valid_count), 128'(32));
        for (int unsigned i = 0; i < 32; i++) begin
            if (i == 5)
                rd_check("ovw5", 5'd5, mk(MULT, -16'sd3, 16'sd11, -32'sd33, 1'b0), 1'b1);
            else
                rd_check($sformatf("stream%0d", i), 5'(i),
                         mk(SUB, 16'(5 * i), 16'sd7, 32'(5 * int'(i) - 7), 1'b0), 1'b1);
        end
        check("ovw.count", 128'(valid_count), 128'(32));

        // 6a. Collision on a valid entry: @9 holds SUB 45-7=38
        wr(5'd9, ADD, 16'sd1000, 16'sd1);
        read_pointer = 5'd9;
        @(negedge clk);
`ifdef IR_FWD_EN
        check("coll.word", 128'(instruction_word), 128'(mk(ADD, 16'sd1000, 16'sd1, 32'sd1001, 1'b0)));
`else
        check("coll.word", 128'(instruction_word), 128'(mk(SUB, 16'sd45, 16'sd7, 32'sd38, 1'b0)));
`endif
        check("coll.valid", 128'(rd_valid), 128'(1));
        rd_check("coll.after", 5'd9, mk(ADD, 16'sd1000, 16'sd1, 32'sd1001, 1'b0), 1'b1);

        // 6b. Reset while a write sits in S1
        load_en = 1'b1; write_pointer = 5'd2; opcode = PASSA;
        operand_a = 16'sd77; operand_b = 16'sd0;
        @(negedge clk);
        load_en = 1'b0;
        check("rstmid.inflight", 128'(wr_inflight), 128'(1));
        reset_n = 1'b0;
        #1;
        check("rstmid.inflight_clr", 128'(wr_inflight), 128'(0));
        check("rstmid.count0", 128'(valid_count), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        rd_check("rstmid.rd2", 5'd2, '0, 1'b0);
        check("rstmid.count", 128'(valid_count), 128'(0));

        // 6c. Collision on an invalid entry
        wr(5'd9, PASSB, 16'sd4, -16'sd2);
        read_pointer = 5'd9;
        @(negedge clk);
`ifdef IR_FWD_EN
        check("coll0.word", 128'(instruction_word), 128'(mk(PASSB, 16'sd4, -16'sd2, -32'sd2, 1'b0)));
        check("coll0.valid", 128'(rd_valid), 128'(1));
`else
        check("coll0.word", 128'(instruction_word), 128'(0));
        check("coll0.valid", 128'(rd_valid), 128'(0));
`endif
        rd_check("coll0.after", 5'd9, mk(PASSB, 16'sd4, -16'sd2, -32'sd2, 1'b0), 1'b1);
        check("coll0.count", 128'(valid_count), 128'(1));

        // ZERO opcode clears result, dbz stays 0
        wr(5'd0, ZERO, 16'sd123, 16'sd0);
        idle(1);
        rd_check("zero", 5'd0, mk(ZERO, 16'sd123, 16'sd0, 32'sd0, 1'b0), 1'b1);
        check("final.count", 128'(valid_count), 128'(2));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
